// File: rtl/aes128_output_serializer.sv
// AES-128 output serializer: takes one 128-bit ciphertext block and emits it
// as NUM_BYTES bytes, most significant byte first, with valid/ready
// handshakes on both sides. A new block can be accepted on the same edge that
// transfers the final byte, giving zero-bubble back-to-back blocks.
module aes128_output_serializer #(
  parameter int NUM_BYTES = 16,
  parameter int DWIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          blk_valid_i,
  input  logic [NUM_BYTES*DWIDTH-1:0]   blk_data_i,
  output logic                          blk_ready_o,
  output logic                          byte_valid_o,
  output logic [DWIDTH-1:0]             byte_out,
  input  logic                          byte_ready_i,
  output logic                          last_o,
  output logic                          blk_done_o,
  output logic                          busy_o
);

  localparam int IW = $clog2(NUM_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                        state;
  logic [IW-1:0]                 idx;
  logic [NUM_BYTES*DWIDTH-1:0]   blk_q;
  logic [DWIDTH-1:0]             byte_sel;
  logic                          at_last;

  // Byte index decode and block-side ready; ready is forced low during reset.
  always_comb begin
    at_last     = (state == SHIFT) && (idx == LAST_IDX);
    blk_ready_o = rst_n && ((state == IDLE) || (at_last && byte_ready_i));
  end

  // Select the current byte; byte 0 occupies the top bits of the block.
  always_comb begin
    byte_sel = '0;
    for (int unsigned i = 0; i < NUM_BYTES; i++) begin
      if (idx == IW'(i)) begin
        byte_sel = blk_q[(NUM_BYTES-1-i)*DWIDTH +: DWIDTH];
      end
    end
  end

  // Output decode from the held state; zeroed while idle.
  always_comb begin
    byte_valid_o = (state == SHIFT);
    busy_o       = (state == SHIFT);
    last_o       = at_last;
    byte_out     = (state == SHIFT) ? byte_sel : '0;
  end

  // FSM: load blocks, step the byte index on each byte handshake, and pulse
  // blk_done_o the cycle after the final byte is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      blk_q      <= '0;
      blk_done_o <= 1'b0;
    end else begin
      blk_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (blk_valid_i) begin
            blk_q <= blk_data_i;
            idx   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (byte_ready_i) begin
            if (idx == LAST_IDX) begin
              blk_done_o <= 1'b1;
              idx        <= '0;
              if (blk_valid_i) begin
                blk_q <= blk_data_i;
              end else begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes128_output_serializer.md
AES128_OUTPUT_SERIALIZER -- requirements
Module: aes128_output_serializer

Interface
REQ-001 Parameters SHALL be: NUM_BYTES, 16, bytes per block; DWIDTH, 8, output byte width.
REQ-002 clk  input  1  single clock; all state SHALL change only on its rising edge, except on reset.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 blk_valid_i  input  1  upstream 128-bit block is valid.
REQ-005 blk_data_i  input  128  block to serialize (AES ciphertext).
REQ-006 blk_ready_o  output  1  serializer can take a block this cycle.
REQ-007 byte_valid_o  output  1  byte_out holds a valid byte.
REQ-008 byte_out  output  8  current output byte.
REQ-009 byte_ready_i  input  1  downstream accepts byte_out this cycle.
REQ-010 last_o  output  1  byte_out is the final byte (index 15) of its block.
REQ-011 blk_done_o  output  1  one-cycle pulse, registered, after the last byte of a block is accepted.
REQ-012 busy_o  output  1  high while a block is held (state SHIFT).

Function
REQ-013 The block accept handshake SHALL be blk_valid_i and blk_ready_o high on the same edge. The byte handshake SHALL be byte_valid_o and byte_ready_i high on the same edge.
REQ-014 The FSM SHALL have exactly two states:
- IDLE: no block held.
- SHIFT: block held in a 128-bit register, byte index in a 4-bit counter idx.
REQ-015 IDLE transitions:
- blk_ready_o = 1.
- On block accept: load the register from blk_data_i, set idx = 0, go to SHIFT.
REQ-016 SHIFT outputs:
- byte_valid_o = 1.
- byte_out = register bits [127-8*idx -: 8]; byte 0 is bits [127:120], sent first.
- last_o = (idx == 15).
REQ-017 In SHIFT, on a byte handshake with idx < 15: idx SHALL increment by 1. The register contents SHALL be unchanged.
REQ-018 In SHIFT, with idx == 15: blk_ready_o SHALL equal byte_ready_i (combinational), so a new block can be accepted on the same edge as the final byte, with zero-bubble back-to-back blocks.
REQ-019 On the final-byte handshake (idx == 15):
- With a simultaneous block accept: load the new block, set idx = 0, stay in SHIFT.
- Otherwise: go to IDLE; idx wraps to 0.
REQ-020 In SHIFT with idx < 15, blk_ready_o SHALL be 0.
REQ-021 When byte_ready_i is low in SHIFT:
- byte_out, last_o, idx and the register SHALL hold.
- byte_valid_o SHALL stay 1; it SHALL never drop while a byte is pending.
REQ-022 blk_done_o SHALL be 1 in the cycle after each final-byte handshake, and 0 otherwise.
REQ-023 In IDLE, byte_valid_o, last_o and busy_o SHALL be 0, and byte_out SHALL be 8'h00.
REQ-024 Block throughput SHALL be 16 cycles per block with byte_ready_i held high. Latency from block accept to first byte_valid_o SHALL be 1 cycle.
REQ-025 blk_data_i SHALL be ignored when no block accept occurs. blk_valid_i high in SHIFT (idx < 15) SHALL NOT disturb state.

Reset
REQ-026 While rst_n = 0, asynchronously: state = IDLE, idx = 0, register = 0, blk_done_o = 0, and all outputs at the REQ-023 values, with blk_ready_o = 1 once rst_n has deasserted.
REQ-027 Reset asserted mid-block SHALL discard the held block. After release, no remaining bytes and no blk_done_o pulse SHALL be emitted.
REQ-028 blk_ready_o SHALL be 0 while rst_n = 0.

Verification
REQ-029 Single block: block 0x00112233445566778899AABBCCDDEEFF, byte_ready_i = 1 -> bytes 00,11,...,FF on 16 consecutive cycles starting 1 cycle after accept; last_o only with FF; blk_done_o one pulse the next cycle; returns to IDLE.
REQ-030 Back-to-back: two blocks A, B, blk_valid_i held high, byte_ready_i = 1 -> B is accepted on the edge that transfers A's byte 15; 32 consecutive valid bytes with no gap; two blk_done_o pulses 16 cycles apart.
REQ-031 Backpressure: byte_ready_i = 0 for 5 cycles at idx = 7 -> byte_out stays at byte 7 with byte_valid_o = 1; sequence resumes intact; total 21 cycles for the block.
REQ-032 Stall at last byte: idx = 15, byte_ready_i = 0, blk_valid_i = 1 -> blk_ready_o = 0 and the new block is not loaded; the block loads on the first cycle byte_ready_i = 1.
REQ-033 Reset mid-block: rst_n low at idx = 9 -> byte_valid_o = 0 immediately (asynchronous); after release, IDLE, no stale bytes and no blk_done_o pulse.
REQ-034 Ignore while busy: blk_valid_i = 1 with different data at idx = 3 -> output stream unchanged and blk_ready_o = 0.
